// File: rtl/pio_pkg.sv
// Register map and edge-type encodings shared by the input and output PIO blocks.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int deb_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer followed by a stable-count debouncer.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic deb
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb = sync2_q;
  end else begin : g_debounce
    localparam int CW = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Any cycle where the synchronized pin agrees with deb restarts the count.
    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
        if (cnt_q == CNT_LAST) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb = deb_q;
  end

endmodule

// File: rtl/pio_edge_input.sv
// Avalon-MM input PIO: debounced pins, sticky edge capture and masked level irq.
module pio_edge_input
  import pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic             irq_q, irq_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .pin  (in_port[i]),
      .deb  (deb[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    deb_dly_d = deb;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_hit = ~deb_dly_q & deb;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_hit = deb_dly_q ^ deb;
    end else begin
      edge_hit = deb_dly_q & ~deb;
    end

    irq_mask_d = irq_mask_q;
    if (wr_en && (address == PIO_ADDR_MASK)) begin
      irq_mask_d = writedata;
    end

    // New edges are OR-ed in after the clear so a coincident edge survives.
    edge_capture_d = edge_capture_q;
    if (wr_en && (address == PIO_ADDR_EDGE)) begin
      edge_capture_d = edge_capture_q & ~writedata;
    end
    edge_capture_d = edge_capture_d | edge_hit;

    irq_d = |(edge_capture_q & irq_mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_dly_q      <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      deb_dly_q      <= deb_dly_d;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      irq_q          <= irq_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA: readdata = deb;
      PIO_ADDR_MASK: readdata = irq_mask_q;
      PIO_ADDR_EDGE: readdata = edge_capture_q;
      default:       readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_pio_edge_input.sv
// Bench for pio_edge_input: directed scenarios plus random pins/bus against a pin-history model.
module tb_pio_edge_input;

  localparam int W  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_port = '0;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [W-1:0] writedata = '0;
  logic [W-1:0] readdata;
  logic         irq;

  always #5 clk = ~clk;

  pio_edge_input #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC),
    .EDGE_TYPE(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: deb flips once the last DC synchronized samples all disagree with it.
  typedef struct {
    logic [W-1:0] rd;
    logic         irq;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] hist[0:DC];
  logic [W-1:0] deb_m = '0, deb_prev_m = '0, ec_m = '0, mask_m = '0;
  logic         irq_m = 1'b0;
  bit           started = 1'b0;

  always begin : model_p
    logic [W-1:0] nd, ed;
    logic         flip;
    exp_t         e;
    @(posedge clk);
    if (reset) begin
      started = 1'b1;
      deb_m = '0; deb_prev_m = '0; ec_m = '0; mask_m = '0; irq_m = 1'b0;
      for (int j = 0; j <= DC; j++) hist[j] = '0;
    end else if (started) begin
      ed    = deb_prev_m & ~deb_m;
      irq_m = |(ec_m & mask_m);
      if (chipselect && !write_n && address == 2'd3) ec_m = (ec_m & ~writedata) | ed;
      else ec_m = ec_m | ed;
      if (chipselect && !write_n && address == 2'd2) mask_m = writedata;
      for (int b = 0; b < W; b++) begin
        flip = 1'b1;
        for (int j = 1; j <= DC; j++) if (hist[j][b] == deb_m[b]) flip = 1'b0;
        nd[b] = flip ? ~deb_m[b] : deb_m[b];
      end
      for (int j = DC; j > 0; j--) hist[j] = hist[j-1];
      hist[0]    = in_port;
      deb_prev_m = deb_m;
      deb_m      = nd;
    end
    #1;
    if (started) begin
      case (address)
        2'd0:    e.rd = deb_m;
        2'd2:    e.rd = mask_m;
        2'd3:    e.rd = ec_m;
        default: e.rd = '0;
      endcase
      e.irq = irq_m;
      sb_q.push_back(e);
    end
  end

  always begin : monitor_p
    exp_t e;
    @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("sb_rd_a%0d", address), readdata, e.rd);
      check("sb_irq", irq, e.irq);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [W-1:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  initial begin
    int hold;
    int op;
    cyc(2);
    reset   = 1'b0;
    in_port = 4'hF;
    cyc(5); chk_rd("t1_lat_early", 2'd0, 4'h0);
    cyc(1); chk_rd("t1_data", 2'd0, 4'hF); chk_rd("t1_edge", 2'd3, 4'h0);
    check("t1_irq", irq, 1'b0);

    in_port = 4'hB;
    cyc(5); chk_rd("t2_lat_early", 2'd0, 4'hF);
    cyc(1); chk_rd("t2_data", 2'd0, 4'hB); chk_rd("t2_edge_early", 2'd3, 4'h0);
    cyc(1); chk_rd("t2_edge", 2'd3, 4'h4);
    cyc(2); check("t2_irq_masked", irq, 1'b0);

    wr(2'd2, 4'h4);
    in_port = 4'hF; cyc(8);
    wr(2'd3, 4'hF);
    in_port = 4'hB;
    cyc(7); chk_rd("t3_edge", 2'd3, 4'h4); check("t3_irq_early", irq, 1'b0);
    cyc(1); check("t3_irq_set", irq, 1'b1);
    wr(2'd3, 4'h4);
    chk_rd("t3_cleared", 2'd3, 4'h0); check("t3_irq_lag", irq, 1'b1);
    cyc(1); check("t3_irq_clr", irq, 1'b0);

    in_port = 4'hF; cyc(8); wr(2'd3, 4'hF);
    in_port = 4'hE; cyc(3); in_port = 4'hF; cyc(10);
    chk_rd("t4_glitch_data", 2'd0, 4'hF); chk_rd("t4_glitch_edge", 2'd3, 4'h0);
    in_port = 4'hE; cyc(4); in_port = 4'hF; cyc(10);
    chk_rd("t4_min_pulse_edge", 2'd3, 4'h1);
    wr(2'd3, 4'hF);

    in_port = 4'hD; cyc(6);
    wr(2'd3, 4'h2);
    chk_rd("t5_set_wins", 2'd3, 4'h2);
    wr(2'd3, 4'h2);
    chk_rd("t5_clear", 2'd3, 4'h0);

    in_port = 4'hF; cyc(8);
    wr(2'd3, 4'hF); wr(2'd2, 4'hF);
    in_port = 4'hA;
    cyc(7); chk_rd("t6_edge", 2'd3, 4'h5);
    cyc(1); check("t6_irq_pre", irq, 1'b1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check("t6_irq_rst", irq, 1'b0);
    chk_rd("t6_data_rst", 2'd0, 4'h0); chk_rd("t6_rsvd", 2'd1, 4'h0);
    @(negedge clk);
    chk_rd("t6_mask_rst", 2'd2, 4'h0); chk_rd("t6_edge_rst", 2'd3, 4'h0);

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        in_port = in_port ^ 4'($urandom_range(1, 15));
        hold    = $urandom_range(1, 8);
      end
      hold--;
      reset     = ($urandom_range(0, 399) == 0);
      op        = $urandom_range(0, 9);
      address   = 2'($urandom_range(0, 3));
      writedata = 4'($urandom);
      if (op < 4) begin
        chipselect = 1'b0; write_n = 1'b1;
      end else if (op < 8) begin
        chipselect = 1'b1; write_n = 1'b1;
      end else if (op == 8) begin
        chipselect = 1'b1; write_n = 1'b0;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b0;
      end
      @(negedge clk);
    end

    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_edge_input.md
Name: pio_edge_input

Overview:
- Avalon-MM slave input port for push-buttons and switches.
- Complements the existing LED output PIO: data flows from the pins to the processor.
- Synchronizes and debounces each input bit, then captures edges in sticky registers.
- Raises a level interrupt to the Tiger MIPS processor through a per-bit mask.

Parameters:
- WIDTH, 4: number of input bits.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the debounced value changes. 0 bypasses debounce.
- EDGE_TYPE, 0: 0 = falling edge, 1 = rising edge, 2 = any edge.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_port  input  WIDTH  asynchronous pin inputs.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  WIDTH  write data.
- readdata  output  WIDTH  read data, combinational from address.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
  - On reset all of the following clear to 0: sync flops, debounce counters, debounced value, irq_mask, edge_capture, irq.
  - Reset mid-debounce discards the count.
  - After reset, pins already at 0 produce no edge. Pins at 1 produce a rising edge after the full latency.
- Synchronizer: two flops per bit, sync1 then sync2.
- Debounce, per bit:
  - When sync2 differs from deb, cnt increments.
  - When sync2 equals deb, cnt clears to 0.
  - When cnt reaches DEBOUNCE_CYCLES-1 while sync2 still differs, deb takes sync2 and cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches deb.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1. It never wraps.
- Latency:
  - Pin change to deb: 2 + DEBOUNCE_CYCLES cycles.
  - With DEBOUNCE_CYCLES = 0: 2 cycles, deb = sync2 registered.
- Edge detect:
  - deb_d is deb delayed one cycle.
  - Falling edge: deb_d & ~deb. Rising edge: ~deb_d & deb. Any edge: XOR.
  - An edge sets its edge_capture bit one cycle after deb changes.
- Register map (word addresses):
  - 0 data: RO, reads deb. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irq_mask: RW, WIDTH bits.
  - 3 edge_capture: read returns sticky bits. A write clears each bit where writedata is 1 (write-1-to-clear).
- Write qualification:
  - A write occurs when chipselect & ~write_n & address match, sampled at the clk edge.
  - No wait states. readdata is valid in the same cycle as address and chipselect.
  - readdata is 0 when address selects no readable register. It does not depend on chipselect.
- Simultaneous events: if a new edge and a clear hit the same edge_capture bit in the same cycle, set wins and the bit stays 1.
- IRQ:
  - irq is registered: irq <= |(edge_capture & irq_mask).
  - It asserts one cycle after edge_capture becomes nonzero under the mask.
  - It deasserts one cycle after a clear or an unmask.
  - Changing the mask does not alter edge_capture.

Decomposition:
- Shared package pio_pkg holds:
  - Register address constants: PIO_ADDR_DATA = 0, PIO_ADDR_MASK = 2, PIO_ADDR_EDGE = 3.
  - EDGE_TYPE encodings: EDGE_FALL = 0, EDGE_RISE = 1, EDGE_ANY = 2.
  - Both are reused by the existing output PIO.
- One sub-module, pio_debounce_bit: a single-bit synchronizer plus debounce counter, instantiated WIDTH times through a generate loop.
- Edge capture, registers and read mux stay in the top level.

Test Plan (WIDTH = 4, DEBOUNCE_CYCLES = 4, EDGE_TYPE = 0):
- Reset, then drive in_port = 4'hF and read addr 0 at cycle 7 → readdata = 4'hF. edge_capture = 0, irq = 0.
- From 4'hF, drive bit 2 low and hold. Read addr 0 → 4'hB after 6 cycles. Edge_capture reads 4'h4 one cycle later. irq stays 0 because the mask is 0.
- Write mask = 4'h4, then create a bit-2 falling edge → irq = 1. Write 4'h4 to addr 3 → edge_capture = 0 and irq = 0 on the following cycle.
- Pulse bit 0 low for 3 cycles, then return high → addr 0 unchanged at 4'hF. edge_capture bit 0 stays 0.
- Issue the addr 3 clear of bit 1 in the same cycle as a new bit-1 edge → edge_capture bit 1 stays 1.
- Assert reset for one cycle with edge_capture = 4'h5, mask = 4'hF and irq = 1 → all read 0 and irq = 0 next cycle. Addr 1 reads 0.
